aer_receiver: RTL and testbench
===============================

Name: aer_receiver

Overview:
- Receiving end of the address-event spike bus. Accepts {spike_in, address_in} requests from the upstream priority arbiter/encoder over a 4-phase req/ack handshake, buffers addresses in a small FIFO, and re-emits each event as a single-cycle one-hot pulse on the destination neuron's spike line.
- Sits at the input of a neuron layer; all logic in one clock domain.

Parameters:
- N_NEURONS, 16, number of destination spike lines.
- ADDR_W, 4, address width; N_NEURONS <= 2**ADDR_W.
- FIFO_DEPTH, 4, event buffer entries; power of two, >= 2.
- CNT_W, 16, width of the saturating event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- spike_in  in  1  request from the encoder; address_in must be stable while it is high.
- address_in  in  ADDR_W  index of the spiking source neuron.
- ack_out  out  1  handshake acknowledge to the encoder.
- out_en  in  1  drain enable; 0 stalls output emission.
- spikes_out  out  N_NEURONS  one-hot, single-cycle spike pulses.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- event_count  out  CNT_W  count of accepted valid events; saturates at all-ones.
- addr_err  out  1  sticky flag: an address >= N_NEURONS was received.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - ack_out=0, spikes_out=0, FIFO empty, fifo_level=0, event_count=0, addr_err=0.
  - FSM enters WAIT_LOW.
- FSM states: WAIT_LOW, IDLE, ACK.
  - WAIT_LOW, ack_out=0: go to IDLE on the first edge with spike_in=0. This guarantees a request held across reset is never captured twice.
  - IDLE, ack_out=0: if spike_in=1 and FIFO not full, capture address_in at this edge and go to ACK. If spike_in=1 and FIFO full, hold in IDLE with no ack; backpressure is by withholding ack.
  - ACK, ack_out=1: stay while spike_in=1; go to IDLE on the edge with spike_in=0.
  - ack_out is a registered decode of state == ACK.
- Handshake timing:
  - spike_in sampled high at edge k → push at edge k, ack_out high after edge k.
  - spike_in sampled low at edge m → ack_out low after edge m.
  - Minimum full cycle is 2 clocks per event. An encoder that keeps spike_in high (a new source becomes pending without first dropping req) still yields only one event per low phase.
- Capture rules:
  - address_in < N_NEURONS: pushed to FIFO; event_count increments, saturating.
  - address_in >= N_NEURONS: acknowledged normally, not pushed, not counted; addr_err set until reset.
- Push decision uses the current-cycle full flag only. A pop in the same cycle does not free a slot for a push.
- Output:
  - Every cycle with FIFO non-empty and out_en=1, pop the head; spikes_out = (1 << head) for exactly one cycle after the edge.
  - Otherwise spikes_out=0.
  - Event captured into an empty FIFO at edge k appears on spikes_out after edge k+1, i.e. 2-cycle request-to-pulse latency.
- Simultaneous push and pop (FIFO non-full and non-empty): both occur; level unchanged.
- Ordering: strict FIFO. Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by the extra pointer bit. No overflow is possible, and underflow is prevented by the empty gate.
- out_en=0: spikes_out=0; FIFO holds contents and accepts pushes until full.

Decomposition:
- Shared package aer_pkg:
  - ADDR_W and N_NEURONS defaults.
  - FSM state enum: WAIT_LOW, IDLE, ACK.
  - clog2 helper function.
- The sender-side arbiter/encoder uses the same ADDR_W and N_NEURONS constants.
- One sub-module: aer_event_fifo, a synchronous single-clock FIFO with parameters WIDTH and DEPTH, push/pop/full/empty/level. The FSM, address check, counter and one-hot decode stay in aer_receiver.

Test Plan:
- Single event, address 5, out_en=1:
  - ack_out rises 1 cycle after spike_in; spikes_out=16'h0020 for one cycle, 2 cycles after spike_in.
  - ack_out falls 1 cycle after spike_in falls; event_count=1.
- Five back-to-back events, addresses 0, 3, 7, 12, 15, with out_en=0:
  - First four acked, fifo_level=4; fifth gets no ack.
  - Raise out_en: pulses 0001, 0008, 0080, 1000 in order, then fifth acked and 8000 emitted.
- Reset with spike_in held high (address 9) and rst_n pulsed low mid-ACK:
  - ack_out drops immediately, FIFO empties.
  - No capture until spike_in goes low then high again; then exactly one 0200 pulse.
- Event at full FIFO while a pop occurs in the same cycle: push blocked that cycle, accepted the next cycle; ordering preserved.
- N_NEURONS=12, address 13:
  - Acked, addr_err=1, no pulse, event_count unchanged.
  - A following address 2 gives pulse 0004.
- CNT_W=3, ten valid events: event_count saturates at 7; all ten pulses emitted.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared constants, FSM state encoding and helpers for the address-event bus.
// Sender-side arbiter/encoder and receiver both pull AER_ADDR_W / AER_N_NEURONS
// from here so the two ends of the link always agree on the address space.
package aer_pkg;

    localparam int unsigned AER_ADDR_W    = 4;
    localparam int unsigned AER_N_NEURONS = 16;

    // Receiver handshake FSM states.
    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACK      = 2'd2
    } aer_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((result < 31) && ((32'd1 << result) < value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/aer_receiver_if.sv
// Address-event request/acknowledge link between encoder (master) and
// receiver (slave).
//   spike_in   : request, master -> slave
//   address_in : source neuron index, stable while spike_in is high
//   ack_out    : acknowledge, slave -> master
interface aer_receiver_if
    import aer_pkg::*;
#(
    parameter int unsigned ADDR_W = AER_ADDR_W
);

    logic              spike_in;
    logic [ADDR_W-1:0] address_in;
    logic              ack_out;

    modport master (
        output spike_in,
        output address_in,
        input  ack_out
    );

    modport slave (
        input  spike_in,
        input  address_in,
        output ack_out
    );

endinterface

// File: rtl/aer_event_fifo.sv
// Synchronous single-clock FIFO holding pending event addresses.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write wdata_i (ignored when full)
//   wdata_i    : entry to write
//   pop_i      : drop head entry (ignored when empty)
//   head_c     : current head entry (combinational read)
//   full_c     : no free slot
//   empty_c    : no stored entry
//   level_o    : registered occupancy
module aer_event_fifo
    import aer_pkg::*;
#(
    parameter int unsigned WIDTH = AER_ADDR_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_c,
    output logic                    full_c,
    output logic                    empty_c,
    output logic [clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_q, wr_d;
    logic [PTR_W:0]   rd_q, rd_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign empty_c = (wr_q == rd_q);
    assign full_c  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign head_c  = mem_q[rd_q[PTR_W-1:0]];
    assign level_o = level_q;

    // Pointer and occupancy next-state.
    always_comb begin
        do_push = push_i && !full_c;
        do_pop  = pop_i && !empty_c;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) begin
            wr_d = wr_q + LVL_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + LVL_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/aer_receiver.sv
// Receiving end of the address-event spike bus: 4-phase req/ack capture,
// address range check, event buffering and one-hot spike re-emission.
//   clk, rst_n  : clock, async active-low reset
//   bus         : req/ack/address link from the encoder (slave side)
//   out_en      : drain enable, 0 stalls emission
//   spikes_out  : one-hot single-cycle spike pulse per popped event
//   fifo_level  : buffered event count
//   event_count : saturating count of accepted in-range events
//   addr_err    : sticky, an out-of-range address was received
module aer_receiver
    import aer_pkg::*;
#(
    parameter int unsigned N_NEURONS  = AER_N_NEURONS,
    parameter int unsigned ADDR_W     = AER_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    aer_receiver_if.slave               bus,
    input  logic                        out_en,
    output logic [N_NEURONS-1:0]        spikes_out,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [CNT_W-1:0]            event_count,
    output logic                        addr_err
);

    aer_state_e             state_q, state_d;

    logic                   ack_q, ack_d;
    logic [N_NEURONS-1:0]   spikes_q, spikes_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   capture_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   addr_ok_c;
    logic                   full_c;
    logic                   empty_c;
    logic [ADDR_W-1:0]      head_c;

    assign addr_ok_c = (32'(bus.address_in) < N_NEURONS);

    // State register; reset lands in WAIT_LOW so a request held across
    // reset must drop before it can be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: backpressure is simply staying in IDLE while full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOW: if (!bus.spike_in)              state_d = ST_IDLE;
            ST_IDLE:     if (bus.spike_in && !full_c)    state_d = ST_ACK;
            ST_ACK:      if (!bus.spike_in)              state_d = ST_IDLE;
            default:                                     state_d = ST_WAIT_LOW;
        endcase
    end

    // Output/datapath decode. Push uses only this cycle's full flag, so a
    // simultaneous pop never opens a slot for the same-cycle request.
    always_comb begin
        capture_c = (state_q == ST_IDLE) && bus.spike_in && !full_c;
        push_c    = capture_c && addr_ok_c;
        pop_c     = out_en && !empty_c;
        ack_d     = (state_d == ST_ACK);
        spikes_d  = '0;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (pop_c) begin
            spikes_d = N_NEURONS'(1) << head_c;
        end
        if (push_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (capture_c && !addr_ok_c) begin
            err_d = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            spikes_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            spikes_q <= spikes_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    aer_event_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .wdata_i (bus.address_in),
        .pop_i   (pop_c),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level_o (fifo_level)
    );

    assign bus.ack_out = ack_q;
    assign spikes_out  = spikes_q;
    assign event_count = cnt_q;
    assign addr_err    = err_q;

endmodule

// File: tb/tb_aer_receiver.sv
// Directed bench for aer_receiver: a default instance (16 neurons, 16-bit
// counter) and a narrow one (12 neurons, 3-bit counter).
module tb_aer_receiver;
    import aer_pkg::*;

    typedef struct {
        logic        spike;
        logic [3:0]  addr;
        logic        oe;
        logic        ack;
        logic [15:0] sp;
        logic [2:0]  lvl;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    aer_receiver_if #(.ADDR_W(4)) bus_a ();
    aer_receiver_if #(.ADDR_W(4)) bus_b ();

    logic        oe_a, oe_b;
    logic [15:0] sp_a;
    logic [2:0]  lvl_a;
    logic [15:0] cnt_a;
    logic        err_a;
    logic [11:0] sp_b;
    logic [2:0]  lvl_b;
    logic [2:0]  cnt_b;
    logic        err_b;

    int checks   = 0;
    int errors   = 0;
    int pulses_b = 0;

    aer_receiver #(
        .N_NEURONS(16), .ADDR_W(4), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .out_en(oe_a),
        .spikes_out(sp_a), .fifo_level(lvl_a), .event_count(cnt_a),
        .addr_err(err_a)
    );

    aer_receiver #(
        .N_NEURONS(12), .ADDR_W(4), .FIFO_DEPTH(4), .CNT_W(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .out_en(oe_b),
        .spikes_out(sp_b), .fifo_level(lvl_b), .event_count(cnt_b),
        .addr_err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic s, input logic [3:0] a, input logic oe,
                          input logic ea, input logic [15:0] es,
                          input logic [2:0] el, input string tag);
        @(negedge clk);
        bus_a.spike_in   = s;
        bus_a.address_in = a;
        oe_a             = oe;
        @(posedge clk);
        #1;
        check($sformatf("%s ack", tag), 32'(bus_a.ack_out), 32'(ea));
        check($sformatf("%s spikes", tag), 32'(sp_a), 32'(es));
        check($sformatf("%s level", tag), 32'(lvl_a), 32'(el));
    endtask

    task automatic step_b(input logic s, input logic [3:0] a, input logic oe,
                          input logic ea, input logic [11:0] es,
                          input logic [2:0] el, input string tag);
        @(negedge clk);
        bus_b.spike_in   = s;
        bus_b.address_in = a;
        oe_b             = oe;
        @(posedge clk);
        #1;
        if (sp_b != '0) pulses_b++;
        check($sformatf("%s ack", tag), 32'(bus_b.ack_out), 32'(ea));
        check($sformatf("%s spikes", tag), 32'(sp_b), 32'(es));
        check($sformatf("%s level", tag), 32'(lvl_b), 32'(el));
    endtask

    initial begin
        vec_t vecs [20];

        rst_n            = 1'b0;
        bus_a.spike_in   = 1'b0;
        bus_a.address_in = 4'd0;
        bus_b.spike_in   = 1'b0;
        bus_b.address_in = 4'd0;
        oe_a             = 1'b0;
        oe_b             = 1'b0;

        // Single event at address 5, then five events with output stalled;
        // the fifth is held off until a pop has completed on a prior edge.
        //            spike addr   oe    ack   spikes    lvl
        vecs[0]  = '{1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[1]  = '{1'b1, 4'd5,  1'b1, 1'b1, 16'h0000, 3'd1};
        vecs[2]  = '{1'b1, 4'd5,  1'b1, 1'b1, 16'h0020, 3'd0};
        vecs[3]  = '{1'b0, 4'd5,  1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[4]  = '{1'b1, 4'd0,  1'b0, 1'b1, 16'h0000, 3'd1};
        vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 3'd1};
        vecs[6]  = '{1'b1, 4'd3,  1'b0, 1'b1, 16'h0000, 3'd2};
        vecs[7]  = '{1'b0, 4'd3,  1'b0, 1'b0, 16'h0000, 3'd2};
        vecs[8]  = '{1'b1, 4'd7,  1'b0, 1'b1, 16'h0000, 3'd3};
        vecs[9]  = '{1'b0, 4'd7,  1'b0, 1'b0, 16'h0000, 3'd3};
        vecs[10] = '{1'b1, 4'd12, 1'b0, 1'b1, 16'h0000, 3'd4};
        vecs[11] = '{1'b0, 4'd12, 1'b0, 1'b0, 16'h0000, 3'd4};
        vecs[12] = '{1'b1, 4'd15, 1'b0, 1'b0, 16'h0000, 3'd4};
        vecs[13] = '{1'b1, 4'd15, 1'b0, 1'b0, 16'h0000, 3'd4};
        vecs[14] = '{1'b1, 4'd15, 1'b1, 1'b0, 16'h0001, 3'd3};
        vecs[15] = '{1'b1, 4'd15, 1'b1, 1'b1, 16'h0008, 3'd3};
        vecs[16] = '{1'b1, 4'd15, 1'b1, 1'b1, 16'h0080, 3'd2};
        vecs[17] = '{1'b0, 4'd15, 1'b1, 1'b0, 16'h1000, 3'd1};
        vecs[18] = '{1'b0, 4'd15, 1'b1, 1'b0, 16'h8000, 3'd0};
        vecs[19] = '{1'b0, 4'd15, 1'b1, 1'b0, 16'h0000, 3'd0};

        #12;
        check("reset ack_a", 32'(bus_a.ack_out), 32'd0);
        check("reset spikes_a", 32'(sp_a), 32'd0);
        check("reset level_a", 32'(lvl_a), 32'd0);
        check("reset count_a", 32'(cnt_a), 32'd0);
        check("reset err_a", 32'(err_a), 32'd0);
        check("reset ack_b", 32'(bus_b.ack_out), 32'd0);
        check("reset count_b", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step_a(vecs[i].spike, vecs[i].addr, vecs[i].oe, vecs[i].ack,
                   vecs[i].sp, vecs[i].lvl, $sformatf("vec%0d", i));
            if (i == 3) check("count after single event", 32'(cnt_a), 32'd1);
        end
        check("count after burst", 32'(cnt_a), 32'd6);
        check("no addr err a", 32'(err_a), 32'd0);

        // Reset asserted mid-ACK with the request still high at address 9.
        step_a(1'b1, 4'd9, 1'b0, 1'b1, 16'h0000, 3'd1, "rst pre");
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst ack", 32'(bus_a.ack_out), 32'd0);
        check("async rst level", 32'(lvl_a), 32'd0);
        check("async rst count", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1'b1, 4'd9, 1'b1, 1'b0, 16'h0000, 3'd0, "held hi 0");
        step_a(1'b1, 4'd9, 1'b1, 1'b0, 16'h0000, 3'd0, "held hi 1");
        step_a(1'b0, 4'd9, 1'b1, 1'b0, 16'h0000, 3'd0, "req low");
        step_a(1'b1, 4'd9, 1'b1, 1'b1, 16'h0000, 3'd1, "req again");
        step_a(1'b1, 4'd9, 1'b1, 1'b1, 16'h0200, 3'd0, "pulse 9");
        step_a(1'b0, 4'd9, 1'b1, 1'b0, 16'h0000, 3'd0, "after 9 a");
        step_a(1'b0, 4'd9, 1'b1, 1'b0, 16'h0000, 3'd0, "after 9 b");
        check("count after reset event", 32'(cnt_a), 32'd1);

        // Narrow instance: out-of-range address, then counter saturation.
        step_b(1'b1, 4'd13, 1'b1, 1'b1, 12'h000, 3'd0, "bad addr");
        check("addr err set", 32'(err_b), 32'd1);
        step_b(1'b0, 4'd13, 1'b1, 1'b0, 12'h000, 3'd0, "bad addr rel");
        check("bad addr not counted", 32'(cnt_b), 32'd0);
        step_b(1'b1, 4'd2, 1'b1, 1'b1, 12'h000, 3'd1, "addr2 req");
        step_b(1'b1, 4'd2, 1'b1, 1'b1, 12'h004, 3'd0, "addr2 pulse");
        step_b(1'b0, 4'd2, 1'b1, 1'b0, 12'h000, 3'd0, "addr2 rel");
        check("count after addr2", 32'(cnt_b), 32'd1);
        for (int k = 0; k < 9; k++) begin
            step_b(1'b1, 4'(k), 1'b1, 1'b1, 12'h000, 3'd1,
                   $sformatf("sat req%0d", k));
            step_b(1'b0, 4'(k), 1'b1, 1'b0, 12'(1 << k), 3'd0,
                   $sformatf("sat rel%0d", k));
            check($sformatf("sat count%0d", k), 32'(cnt_b),
                  32'((k + 2 > 7) ? 7 : k + 2));
        end
        check("pulse total b", 32'(pulses_b), 32'd10);
        check("addr err sticky", 32'(err_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
